// File: rtl/wma_filter_mc.sv
// Multi-channel weighted-moving-average temperature filter with per-channel band thresholds.
// Optional feature: define WMA_ALARM_EN for per-channel consecutive out-of-band alarms.
module wma_filter_mc #(
    parameter int DATA_W    = 8,
    parameter int NUM_CH    = 4,
    parameter int CH_W      = 2,
    parameter int ALARM_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        thr_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_wma,
    output logic [DATA_W-1:0] out_t1,
    output logic [DATA_W-1:0] out_t2,
    output logic              out_in_band,
    output logic              bad_ch
`ifdef WMA_ALARM_EN
   ,output logic [NUM_CH-1:0] alarm
`endif
);

    generate
        if ((2 ** CH_W) < NUM_CH) begin : g_bad_cfg
            $error("wma_filter_mc: CH_W too narrow to index NUM_CH channels");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

    state_t state, next_state;

    logic [CH_W-1:0]   cap_ch;
    logic [DATA_W-1:0] cap_data;
    logic [1:0]        cap_sel;
    logic              cap_bad;

    logic [DATA_W-1:0] wma_r [NUM_CH];
    logic [DATA_W-1:0] t1_r  [NUM_CH];
    logic [DATA_W-1:0] t2_r  [NUM_CH];
    logic [NUM_CH-1:0] seeded_r;

    logic [DATA_W-1:0] cur_wma, cur_t1, cur_t2;
    logic              cur_seeded;
    logic              in_band;
    logic [DATA_W+1:0] sum_ib, sum_ob;
    logic [DATA_W-1:0] new_wma, delta, new_t1, new_t2;
    logic [DATA_W:0]   t2_sum;
    logic [2:0]        shamt;

`ifdef WMA_ALARM_EN
    localparam int CNT_W = $clog2(ALARM_LEN + 1);
    localparam logic [CNT_W-1:0] ALARM_MAX = CNT_W'(ALARM_LEN);
    logic [CNT_W-1:0] cnt_r [NUM_CH];
    logic [CNT_W-1:0] cur_cnt, new_cnt;
`endif

    assign cap_bad = ({1'b0, cap_ch} >= NUM_CH_L);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        bad_ch     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = CALC;
            end
            CALC: begin
                bad_ch     = cap_bad;
                next_state = cap_bad ? IDLE : OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Filter arithmetic for the captured sample; a fresh channel simply seeds with the sample
    always_comb begin
        cur_wma    = wma_r[cap_ch];
        cur_t1     = t1_r[cap_ch];
        cur_t2     = t2_r[cap_ch];
        cur_seeded = seeded_r[cap_ch];
        in_band    = !cur_seeded || ((cap_data >= cur_t1) && (cap_data < cur_t2));
        sum_ib     = {2'b00, cap_data} + {2'b00, cur_wma} + {1'b0, cur_wma, 1'b0};
        sum_ob     = {2'b00, cap_data} + {2'b00, cur_wma};
        if (!cur_seeded)  new_wma = cap_data;
        else if (in_band) new_wma = sum_ib[DATA_W+1:2];
        else              new_wma = sum_ob[DATA_W:1];
        case (cap_sel)
            2'd1:    shamt = 3'd6;
            2'd2:    shamt = 3'd7;
            default: shamt = 3'd5;
        endcase
        delta  = new_wma >> shamt;
        new_t1 = new_wma - delta;
        t2_sum = {1'b0, new_wma} + {1'b0, delta};
        new_t2 = t2_sum[DATA_W] ? {DATA_W{1'b1}} : t2_sum[DATA_W-1:0];
`ifdef WMA_ALARM_EN
        cur_cnt = cnt_r[cap_ch];
        if (in_band)                   new_cnt = '0;
        else if (cur_cnt == ALARM_MAX) new_cnt = ALARM_MAX;
        else                           new_cnt = cur_cnt + 1'b1;
`endif
    end

    // Sample capture, channel write-back and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_ch      <= '0;
            cap_data    <= '0;
            cap_sel     <= '0;
            seeded_r    <= '0;
            out_ch      <= '0;
            out_wma     <= '0;
            out_t1      <= '0;
            out_t2      <= '0;
            out_in_band <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                wma_r[i] <= '0;
                t1_r[i]  <= '0;
                t2_r[i]  <= '0;
            end
`ifdef WMA_ALARM_EN
            alarm <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_r[i] <= '0;
`endif
        end else begin
            if (state == IDLE && in_valid) begin
                cap_ch   <= in_ch;
                cap_data <= in_data;
                cap_sel  <= thr_sel;
            end
            if (state == CALC && !cap_bad) begin
                wma_r[cap_ch]    <= new_wma;
                t1_r[cap_ch]     <= new_t1;
                t2_r[cap_ch]     <= new_t2;
                seeded_r[cap_ch] <= 1'b1;
                out_ch           <= cap_ch;
                out_wma          <= new_wma;
                out_t1           <= new_t1;
                out_t2           <= new_t2;
                out_in_band      <= in_band;
`ifdef WMA_ALARM_EN
                cnt_r[cap_ch] <= new_cnt;
                alarm[cap_ch] <= (new_cnt == ALARM_MAX);
`endif
            end
        end
    end

endmodule

// File: tb/tb_wma_filter_mc.sv
// Self-checking bench for wma_filter_mc: directed scenarios plus randomized samples
// against an arithmetic reference model of the per-channel filter.
module tb_wma_filter_mc;

    localparam int ALARM_LEN = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_ch = '0;
    logic [7:0] in_data = '0;
    logic [1:0] thr_sel = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_ch;
    logic [7:0] out_wma, out_t1, out_t2;
    logic       out_in_band;
    logic       bad_ch;
`ifdef WMA_ALARM_EN
    logic [3:0] alarm;
`endif

    wma_filter_mc #(.DATA_W(8), .NUM_CH(4), .CH_W(2), .ALARM_LEN(ALARM_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
        .thr_sel(thr_sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_wma(out_wma), .out_t1(out_t1), .out_t2(out_t2),
        .out_in_band(out_in_band), .bad_ch(bad_ch)
`ifdef WMA_ALARM_EN
       ,.alarm(alarm)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int m_wma [4];
    int m_t1  [4];
    int m_t2  [4];
    int m_cnt [4];
    bit m_seeded [4];
    logic [3:0] m_alarm;
    int e_wma, e_t1, e_t2, e_ib;
    int obs_wma, obs_t1, obs_t2, obs_ib;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
        else passed++;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            m_wma[i] = 0; m_t1[i] = 0; m_t2[i] = 0; m_cnt[i] = 0; m_seeded[i] = 0;
        end
        m_alarm = '0;
    endtask

    // Reference behaviour of one accepted sample, in plain integer arithmetic
    task automatic modelUpdate(input int ch, input int x, input int sel);
        int w, d, div;
        if (!m_seeded[ch]) begin
            e_ib = 1;
            w = x;
        end else begin
            e_ib = (m_t1[ch] <= x && x < m_t2[ch]) ? 1 : 0;
            w = e_ib ? (x + 3 * m_wma[ch]) / 4 : (x + m_wma[ch]) / 2;
        end
        div = (sel == 1) ? 64 : (sel == 2) ? 128 : 32;
        d = w / div;
        m_wma[ch] = w;
        m_t1[ch] = w - d;
        m_t2[ch] = (w + d > 255) ? 255 : w + d;
        m_seeded[ch] = 1;
        m_cnt[ch] = e_ib ? 0 : ((m_cnt[ch] + 1 > ALARM_LEN) ? ALARM_LEN : m_cnt[ch] + 1);
        m_alarm[ch] = (m_cnt[ch] == ALARM_LEN);
        e_wma = m_wma[ch]; e_t1 = m_t1[ch]; e_t2 = m_t2[ch];
    endtask

    task automatic checkFields(input string ph, input int ch);
        checkOutput({ph, "_ch"},   out_ch, ch);
        checkOutput({ph, "_wma"},  out_wma, e_wma);
        checkOutput({ph, "_t1"},   out_t1, e_t1);
        checkOutput({ph, "_t2"},   out_t2, e_t2);
        checkOutput({ph, "_band"}, out_in_band, e_ib);
`ifdef WMA_ALARM_EN
        checkOutput({ph, "_alarm"}, alarm, m_alarm);
`endif
    endtask

    // Offer one sample, verify latency and results, hold out_ready low for 'hold' cycles;
    // with rst_in_out set, reset is pulsed while the result is being held instead
    task automatic applyStimulus(input int ch, input int x, input int sel, input int hold,
                                 input bit rst_in_out);
        @(negedge clk);
        in_valid = 1'b1; in_ch = 2'(ch); in_data = 8'(x); thr_sel = 2'(sel); out_ready = 1'b0;
        checkOutput("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = ~in_data; thr_sel = ~thr_sel;
        checkOutput("calc_in_ready", in_ready, 0);
        checkOutput("calc_out_valid", out_valid, 0);
        checkOutput("calc_bad_ch", bad_ch, 0);
        modelUpdate(ch, x, sel);
        @(posedge clk); #1;
        checkOutput("out_valid_rise", out_valid, 1);
        checkFields("out", ch);
        obs_wma = out_wma; obs_t1 = out_t1; obs_t2 = out_t2; obs_ib = out_in_band;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_ch = 2'($urandom_range(0, 3)); in_data = 8'($urandom);
            @(posedge clk); #1;
            checkOutput("hold_out_valid", out_valid, 1);
            checkOutput("hold_in_ready", in_ready, 0);
            checkFields("hold", ch);
        end
        if (rst_in_out) begin
            rst_n = 1'b0;
            #1;
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_out_wma", out_wma, 0);
            checkOutput("rst_out_t2", out_t2, 0);
            checkOutput("rst_out_band", out_in_band, 0);
            modelReset();
            @(negedge clk);
            in_valid = 1'b0;
            rst_n = 1'b1;
            #1;
            checkOutput("rst_in_ready", in_ready, 1);
            return;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("done_out_valid", out_valid, 0);
        checkOutput("done_in_ready", in_ready, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int ch, x, sel;
        modelReset();
        #12;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_wma", out_wma, 0);
        checkOutput("reset_bad_ch", bad_ch, 0);
`ifdef WMA_ALARM_EN
        checkOutput("reset_alarm", alarm, 0);
`endif
        rst_n = 1'b1;

        applyStimulus(0, 100, 0, 0, 0);
        checkOutput("dir_seed_wma", obs_wma, 100);
        checkOutput("dir_seed_t1", obs_t1, 97);
        checkOutput("dir_seed_t2", obs_t2, 103);
        checkOutput("dir_seed_band", obs_ib, 1);
        applyStimulus(0, 101, 0, 0, 0);
        checkOutput("dir_ib_wma", obs_wma, 100);
        checkOutput("dir_ib_band", obs_ib, 1);
        applyStimulus(0, 200, 0, 0, 0);
        checkOutput("dir_ob_wma", obs_wma, 150);
        checkOutput("dir_ob_t1", obs_t1, 146);
        checkOutput("dir_ob_t2", obs_t2, 154);
        checkOutput("dir_ob_band", obs_ib, 0);

        applyStimulus(1, 255, 0, 0, 0);
        checkOutput("dir_sat_t1", obs_t1, 248);
        checkOutput("dir_sat_t2", obs_t2, 255);
        applyStimulus(1, 255, 2, 0, 0);
        checkOutput("dir_sel2_t1", obs_t1, 254);
        checkOutput("dir_sel2_t2", obs_t2, 255);

        applyStimulus(2, 50, 0, 5, 0);
        applyStimulus(3, 80, 0, 0, 0);
        applyStimulus(2, 51, 0, 0, 0);
        checkOutput("dir_ch2_wma", obs_wma, 50);
        applyStimulus(3, 80, 0, 0, 0);
        checkOutput("dir_ch3_wma", obs_wma, 80);

        applyStimulus(0, 77, 1, 1, 1);
        applyStimulus(0, 100, 0, 0, 0);
        checkOutput("dir_reseed_wma", obs_wma, 100);
        checkOutput("dir_reseed_band", obs_ib, 1);
        applyStimulus(0, 200, 0, 0, 0);
        applyStimulus(0, 20, 0, 0, 0);
        applyStimulus(0, 200, 0, 0, 0);
        applyStimulus(0, 20, 0, 0, 0);
        checkOutput("dir_alarm_wma", obs_wma, 81);
`ifdef WMA_ALARM_EN
        checkOutput("dir_alarm_set", alarm[0], 1);
`endif
        applyStimulus(0, 80, 0, 0, 0);
        checkOutput("dir_alarm_clr_band", obs_ib, 1);
`ifdef WMA_ALARM_EN
        checkOutput("dir_alarm_clr", alarm[0], 0);
`endif

        for (int n = 0; n < 40; n++) begin
            ch  = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                x = m_wma[ch] + $urandom_range(0, 6) - 3;
                if (x < 0) x = 0;
                if (x > 255) x = 255;
            end else begin
                x = $urandom_range(0, 255);
            end
            applyStimulus(ch, x, sel, $urandom_range(0, 2), 0);
        end

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
